// File: rtl/ov7670_stream_gen.sv
// OV7670-style camera stream generator: PCLK at clk/2, VSYNC/HREF framing and RGB565
// test patterns, with all framing and data outputs launched on the PCLK falling edge.
module ov7670_stream_gen #(
    parameter int unsigned H_ACTIVE = 180,
    parameter int unsigned V_ACTIVE = 120,
    parameter int unsigned H_BLANK  = 144,
    parameter int unsigned VS_LINES = 3,
    parameter int unsigned V_BACK   = 17,
    parameter int unsigned V_FRONT  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        PCLK,
    output logic        VSYNC,
    output logic        HREF,
    output logic [7:0]  D,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned HREF_BYTES = 2 * H_ACTIVE;
    localparam int unsigned MAX_A      = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
    localparam int unsigned MAX_B      = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int unsigned MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned BAR_W      = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int unsigned COL_W      = $clog2(LINE_BYTES + 1);
    localparam int unsigned LINE_W     = $clog2(MAX_LINES + 1);
    localparam int unsigned X_W        = $clog2(LINE_BYTES + 1);
    localparam int unsigned BARP_W     = $clog2(BAR_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t              state_q, state_d;
    logic                pclk_q, pclk_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [BARP_W-1:0]   bar_pos_q, bar_pos_d;
    logic [3:0]          bar_idx_q, bar_idx_d;
    logic [1:0]          pat_q, pat_d;
    logic                vsync_q, vsync_d;
    logic                href_q, href_d;
    logic [7:0]          data_q, data_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;

    logic [LINE_W-1:0]   line_end;
    logic                col_last;
    logic                line_last;
    logic [15:0]         color;
    logic [4:0]          x5;
    logic [5:0]          y6;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pclk_q       <= 1'b0;
            col_q        <= '0;
            line_q       <= '0;
            x_q          <= '0;
            bar_pos_q    <= '0;
            bar_idx_q    <= '0;
            pat_q        <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pclk_q       <= pclk_d;
            col_q        <= col_d;
            line_q       <= line_d;
            x_q          <= x_d;
            bar_pos_q    <= bar_pos_d;
            bar_idx_q    <= bar_idx_d;
            pat_q        <= pat_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pclk_d       = pclk_q;
        col_d        = col_q;
        line_d       = line_q;
        x_d          = x_q;
        bar_pos_d    = bar_pos_q;
        bar_idx_d    = bar_idx_q;
        pat_d        = pat_q;
        vsync_d      = vsync_q;
        href_d       = href_q;
        data_d       = data_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        color        = 16'h0000;
        x5           = 5'(x_d);
        y6           = 6'(line_d);

        case (state_q)
            S_VSYNC:  line_end = LINE_W'(VS_LINES - 1);
            S_VBACK:  line_end = LINE_W'(V_BACK - 1);
            S_ACTIVE: line_end = LINE_W'(V_ACTIVE - 1);
            S_VFRONT: line_end = LINE_W'(V_FRONT - 1);
            default:  line_end = '0;
        endcase
        col_last  = (col_q == COL_W'(LINE_BYTES - 1));
        line_last = (line_q == line_end);

        // In IDLE an enable arms one PCLK high phase so the frame opens on a falling edge
        if (state_q == S_IDLE) begin
            pclk_d = pclk_q ? 1'b0 : enable;
        end else begin
            pclk_d = ~pclk_q;
        end

        if (!pclk_q) begin
            frame_done_d = (state_q == S_VFRONT) && col_last && line_last;
        end else begin
            if (state_q == S_IDLE) begin
                state_d = S_VSYNC;
                col_d   = '0;
                line_d  = '0;
                pat_d   = pattern_sel;
            end else begin
                col_d = col_last ? '0 : col_q + COL_W'(1);
                if (col_last) begin
                    line_d = line_last ? '0 : line_q + LINE_W'(1);
                    if (line_last) begin
                        case (state_q)
                            S_VSYNC:  state_d = S_VBACK;
                            S_VBACK:  state_d = S_ACTIVE;
                            S_ACTIVE: state_d = S_VFRONT;
                            S_VFRONT: begin
                                if (enable) begin
                                    state_d = S_VSYNC;
                                    pat_d   = pattern_sel;
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end
                            default:  state_d = S_IDLE;
                        endcase
                    end
                end
            end

            // Pixel and bar counters advance on each even byte; bar index saturates at 8 (black)
            if (col_d == '0) begin
                x_d       = '0;
                bar_pos_d = '0;
                bar_idx_d = '0;
            end else if (!col_d[0]) begin
                x_d = x_q + X_W'(1);
                if (bar_idx_q != 4'd8) begin
                    if (bar_pos_q == BARP_W'(BAR_W - 1)) begin
                        bar_pos_d = '0;
                        bar_idx_d = bar_idx_q + 4'd1;
                    end else begin
                        bar_pos_d = bar_pos_q + BARP_W'(1);
                    end
                end
            end

            x5 = 5'(x_d);
            y6 = 6'(line_d);
            case (pat_d)
                2'd0: color = solid_color;
                2'd1: color = {x5, y6, ~x5};
                2'd2: color = (x5[3] ^ y6[3]) ? 16'hFFFF : 16'h0000;
                default: begin
                    case (bar_idx_d)
                        4'd0:    color = 16'hFFFF;
                        4'd1:    color = 16'hFFE0;
                        4'd2:    color = 16'h07FF;
                        4'd3:    color = 16'h07E0;
                        4'd4:    color = 16'hF81F;
                        4'd5:    color = 16'hF800;
                        4'd6:    color = 16'h001F;
                        default: color = 16'h0000;
                    endcase
                end
            endcase

            vsync_d = (state_d == S_VSYNC);
            href_d  = (state_d == S_ACTIVE) && (col_d < COL_W'(HREF_BYTES));
            data_d  = href_d ? (col_d[0] ? color[7:0] : color[15:8]) : 8'h00;
            busy_d  = (state_d != S_IDLE);
        end
    end

    assign PCLK       = pclk_q;
    assign VSYNC      = vsync_q;
    assign HREF       = href_q;
    assign D          = data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen: captures bytes on PCLK rising edges, scores them against a
// pattern model and a table of hand-derived spot pixels, plus reset/enable corner sequences.
module tb_ov7670_stream_gen;

    localparam int unsigned HA = 180;
    localparam int unsigned VA = 4;
    localparam int unsigned HB = 4;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 2;
    localparam int unsigned VF = 1;
    localparam int unsigned L  = 2 * HA + HB;
    localparam int unsigned NB = VA * 2 * HA;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_color;
    logic        PCLK;
    logic        VSYNC;
    logic        HREF;
    logic [7:0]  D;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    ov7670_stream_gen #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .H_BLANK  (HB),
        .VS_LINES (VS),
        .V_BACK   (VB),
        .V_FRONT  (VF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .solid_color (solid_color),
        .PCLK        (PCLK),
        .VSYNC       (VSYNC),
        .HREF        (HREF),
        .D           (D),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    typedef struct {
        logic [1:0] pat;
        int         x;
        int         y;
        logic [7:0] hi;
        logic [7:0] lo;
    } spot_t;

    typedef struct {
        logic [1:0]  pat;
        logic [15:0] solid;
    } frame_t;

    spot_t      spots[16];
    frame_t     frames[4];
    logic [7:0] exp_q[$];

    int vectors = 0;
    int fails   = 0;

    // Capture model state, owned by the monitor process
    bit         prev_pclk = 1'b0;
    bit         prev_vs   = 1'b0;
    bit         prev_href = 1'b0;
    bit         in_gap    = 1'b0;
    int         vs_bytes = 0, gap_bytes = 0, href_pulses = 0, bad_len = 0;
    int         idle_nz = 0, nbytes = 0, run_len = 0, fd_total = 0;
    logic [7:0] cap_mem[NB];

    initial forever begin
        @(negedge clk);
        if (frame_done) fd_total++;
        if (PCLK && !prev_pclk) begin
            if (VSYNC && !prev_vs) begin
                vs_bytes = 0; gap_bytes = 0; href_pulses = 0; bad_len = 0;
                idle_nz = 0; nbytes = 0; run_len = 0; in_gap = 1'b0;
            end
            if (!VSYNC && prev_vs) in_gap = 1'b1;
            if (VSYNC) vs_bytes++;
            if (HREF) begin
                if (!prev_href) href_pulses++;
                in_gap = 1'b0;
                run_len++;
                if (nbytes < int'(NB)) cap_mem[nbytes] = D;
                nbytes++;
            end else begin
                if (prev_href && run_len != int'(2 * HA)) bad_len++;
                run_len = 0;
                if (D != 8'h00) idle_nz++;
                if (in_gap) gap_bytes++;
            end
            prev_vs   = VSYNC;
            prev_href = HREF;
        end
        prev_pclk = PCLK;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_pixel(input logic [1:0] pat, input logic [15:0] solid,
                                              input int x, input int y);
        logic [4:0] xr;
        logic [5:0] yg;
        int         bar;
        xr  = x[4:0];
        yg  = y[5:0];
        bar = x / int'(HA / 8);
        case (pat)
            2'd0: return solid;
            2'd1: return {xr, yg, ~xr};
            2'd2: return (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
            default: begin
                case (bar)
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
        endcase
    endfunction

    task automatic push_frame(input logic [1:0] pat, input logic [15:0] solid);
        logic [15:0] p;
        exp_q.delete();
        for (int y = 0; y < int'(VA); y++) begin
            for (int x = 0; x < int'(HA); x++) begin
                p = exp_pixel(pat, solid, x, y);
                exp_q.push_back(p[15:8]);
                exp_q.push_back(p[7:0]);
            end
        end
    endtask

    task automatic wait_vsync();
        bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (VSYNC) begin
                ok = 1'b1;
                break;
            end
        end
        check("vsync_start", int'(ok), 1);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_done_seen", int'(ok), 1);
    endtask

    task automatic check_frame(input logic [1:0] pat, input int fd_exp);
        int         k = 0;
        logic [7:0] e;
        check("vsync_bytes", vs_bytes, int'(VS * L));
        check("back_porch_bytes", gap_bytes, int'(VB * L));
        check("href_pulses", href_pulses, int'(VA));
        check("href_len_errors", bad_len, 0);
        check("d_nonzero_while_href_low", idle_nz, 0);
        check("active_bytes", nbytes, int'(NB));
        check("frame_done_count", fd_total, fd_exp);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("byte[%0d] pat%0d", k, pat), int'(cap_mem[k]), int'(e));
            k++;
        end
        foreach (spots[i]) begin
            if (spots[i].pat == pat) begin
                check($sformatf("spot_hi pat%0d x%0d y%0d", pat, spots[i].x, spots[i].y),
                      int'(cap_mem[(spots[i].y * int'(HA) + spots[i].x) * 2]), int'(spots[i].hi));
                check($sformatf("spot_lo pat%0d x%0d y%0d", pat, spots[i].x, spots[i].y),
                      int'(cap_mem[(spots[i].y * int'(HA) + spots[i].x) * 2 + 1]), int'(spots[i].lo));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " PCLK"}, int'(PCLK), 0);
        check({tag, " VSYNC"}, int'(VSYNC), 0);
        check({tag, " HREF"}, int'(HREF), 0);
        check({tag, " D"}, int'(D), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " frame_done"}, int'(frame_done), 0);
    endtask

    task automatic check_startup(input string tag);
        @(negedge clk);
        check({tag, " pclk_armed"}, int'(PCLK), 1);
        check({tag, " vsync_not_yet"}, int'(VSYNC), 0);
        @(negedge clk);
        check({tag, " pclk_fall"}, int'(PCLK), 0);
        check({tag, " vsync_rise"}, int'(VSYNC), 1);
        check({tag, " busy_rise"}, int'(busy), 1);
    endtask

    initial begin
        int fd_exp = 0;
        int rises  = 0;
        int viol   = 0;
        bit ok;
        bit ph;
        logic [1:0] next_pat;

        frames[0] = '{2'd0, 16'hF800};
        frames[1] = '{2'd1, 16'h1234};
        frames[2] = '{2'd2, 16'h0000};
        frames[3] = '{2'd3, 16'h0000};

        spots[0]  = '{2'd0,   0, 0, 8'hF8, 8'h00};
        spots[1]  = '{2'd0, 179, 3, 8'hF8, 8'h00};
        spots[2]  = '{2'd1,   5, 2, 8'h28, 8'h5A};
        spots[3]  = '{2'd1,   0, 0, 8'h00, 8'h1F};
        spots[4]  = '{2'd1,  31, 3, 8'hF8, 8'h60};
        spots[5]  = '{2'd2,   0, 0, 8'h00, 8'h00};
        spots[6]  = '{2'd2,   8, 0, 8'hFF, 8'hFF};
        spots[7]  = '{2'd2,  16, 1, 8'h00, 8'h00};
        spots[8]  = '{2'd3,   0, 0, 8'hFF, 8'hFF};
        spots[9]  = '{2'd3,  22, 1, 8'hFF, 8'hE0};
        spots[10] = '{2'd3,  44, 0, 8'h07, 8'hFF};
        spots[11] = '{2'd3, 110, 2, 8'hF8, 8'h00};
        spots[12] = '{2'd3, 153, 0, 8'h00, 8'h1F};
        spots[13] = '{2'd3, 154, 0, 8'h00, 8'h00};
        spots[14] = '{2'd3, 176, 3, 8'h00, 8'h00};
        spots[15] = '{2'd3, 179, 3, 8'h00, 8'h00};

        rst = 1'b1;
        enable = 1'b0;
        pattern_sel = 2'd0;
        solid_color = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        pattern_sel = frames[0].pat;
        solid_color = frames[0].solid;
        enable = 1'b1;
        push_frame(frames[0].pat, frames[0].solid);
        rst = 1'b0;
        check_startup("first_frame");
        pattern_sel = ~frames[0].pat;

        // Back-to-back frames, one per pattern; pattern_sel scrambled mid-frame each time
        for (int i = 0; i < 4; i++) begin
            wait_done();
            fd_exp++;
            next_pat = (i < 3) ? frames[i + 1].pat : 2'd1;
            pattern_sel = next_pat;
            if (i < 3) solid_color = frames[i + 1].solid;
            @(negedge clk);
            check_frame(frames[i].pat, fd_exp);
            wait_vsync();
            pattern_sel = ~next_pat;
        end

        // Abort the pattern-1 frame with reset in the middle of an active line
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (HREF) begin
                ok = 1'b1;
                break;
            end
        end
        check("href_before_reset", int'(ok), 1);
        repeat (101) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_frame_reset");
        repeat (2) @(negedge clk);
        check_reset_outputs("mid_frame_reset_hold");
        pattern_sel = 2'd2;
        solid_color = 16'h0000;
        push_frame(2'd2, 16'h0000);
        rst = 1'b0;
        check_startup("after_reset");
        pattern_sel = 2'd0;
        wait_done();
        fd_exp++;
        pattern_sel = 2'd3;
        @(negedge clk);
        check_frame(2'd2, fd_exp);
        push_frame(2'd3, 16'h0000);
        wait_vsync();
        pattern_sel = 2'd1;

        // Drop enable during active line 2; the frame must still complete exactly once
        rises = 0;
        ph = 1'b0;
        for (int i = 0; i < 20000 && rises < 3; i++) begin
            @(negedge clk);
            if (HREF && !ph) rises++;
            ph = HREF;
        end
        check("href_rises_before_drop", rises, 3);
        repeat (40) @(negedge clk);
        enable = 1'b0;
        wait_done();
        fd_exp++;
        @(negedge clk);
        check("busy_after_last_frame", int'(busy), 0);
        check("pclk_after_last_frame", int'(PCLK), 0);
        check_frame(2'd3, fd_exp);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (PCLK || VSYNC || HREF || busy || frame_done) viol++;
        end
        check("idle_activity", viol, 0);
        check("frame_done_total_idle", fd_total, fd_exp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
